lfo_gen_multi: RTL and testbench

Parametrised multi-channel LFO for the chorus/modulation path; successor to the single-channel, sine-only, dip-switch-tuned generator. Uses one shared phase accumulator with a per-channel phase offset (e.g. 180° stereo spread) and one time-multiplexed LUT. Supports four waveforms and exact-unity amplitude scaling. Results go to the delay-line address logic through a valid/ready handshake, once per audio sample tick.

---
 rtl/lfo_gen_multi_if.sv | 20 ++
 rtl/lfo_gen_multi.sv | 224 ++++++++++++++++++++++
 tb/tb_lfo_gen_multi.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/lfo_gen_multi_if.sv
// ============================================================================
// Module : lfo_gen_multi_if
// Brief  : Sample-set handshake between the multi-channel LFO and its consumer
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface lfo_gen_multi_if #(
  parameter int NUM_CH = 2,
  parameter int OUT_W  = 16
);
  logic [NUM_CH*OUT_W-1:0] waveOut;
  logic                    outValid;
  logic                    outReady;

  modport master (output waveOut, output outValid, input outReady);
  modport slave  (input waveOut, input outValid, output outReady);
endinterface

`default_nettype wire

// File: rtl/lfo_gen_multi.sv
// ============================================================================
// Module : lfo_gen_multi
// Brief  : Multi-channel LFO, shared accumulator, time-multiplexed sine table.
//          Define LFO_INTERP_EN for linearly interpolated sine lookup.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module lfo_gen_multi #(
  parameter int NUM_CH  = 2,
  parameter int OUT_W   = 16,
  parameter int ACC_W   = 32,
  parameter int LUT_AW  = 8,
  parameter int SCALE_W = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_sampleTick,
  input  logic [ACC_W-1:0]    i_tuningWord,
  input  logic [ACC_W-1:0]    i_phaseOffset,
  input  logic [1:0]          i_waveSel,
  input  logic [SCALE_W-1:0]  i_scaleFactor,
  lfo_gen_multi_if.master     bus,
  output logic                o_busy,
  output logic                o_overrun
);

  localparam int c_DEPTH = 1 << LUT_AW;
  localparam int c_CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [c_CH_W-1:0]     c_LAST = c_CH_W'(NUM_CH - 1);
  localparam logic [OUT_W-1:0]      c_POS  = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0]      c_NEG  = {1'b1, {(OUT_W-2){1'b0}}, 1'b1};

  // Sine entry k of the table, Q30 Taylor series over the first quadrant.
  function automatic logic [OUT_W-1:0] sine_entry(input int k);
    int     n, idx;
    logic   neg;
    longint x, x2, t, s, v, vmax;
    n    = 1 << LUT_AW;
    idx  = k;
    neg  = 1'b0;
    vmax = (64'sd1 <<< (OUT_W - 1)) - 64'sd1;
    if (idx >= n / 2) begin
      idx = idx - n / 2;
      neg = 1'b1;
    end
    if (idx > n / 4) idx = n / 2 - idx;
    x  = (longint'(idx) * 64'sd6746518852) / longint'(n);
    x2 = (x * x) >>> 30;
    t  = 64'sd1 <<< 30;
    for (int i = 6; i >= 1; i--)
      t = (64'sd1 <<< 30) - ((x2 * t) >>> 30) / longint'((2 * i) * (2 * i + 1));
    s = (x * t) >>> 30;
    v = (s * vmax + (64'sd1 <<< 29)) >>> 30;
    if (v > vmax) v = vmax;
    if (neg) v = -v;
    return v[OUT_W-1:0];
  endfunction

  logic [OUT_W-1:0] w_lut [c_DEPTH];
  for (genvar gi = 0; gi < c_DEPTH; gi++) begin : g_lut
    localparam logic [OUT_W-1:0] c_ENTRY = sine_entry(gi);
    assign w_lut[gi] = c_ENTRY;
  end

`ifdef LFO_INTERP_EN
  typedef enum logic [2:0] {IDLE, ADDR, CALC, HOLD, INTERP} state_t;
`else
  typedef enum logic [1:0] {IDLE, ADDR, CALC, HOLD} state_t;
`endif

  state_t r_state, w_next;
  logic   w_latch, w_write, w_last, w_drop;

  logic [ACC_W-1:0]          r_acc, r_p, r_tw, r_off;
  logic [1:0]                r_sel;
  logic [SCALE_W-1:0]        r_scale;
  logic [c_CH_W-1:0]         r_ch;
  logic [OUT_W-1:0]          r_lut;
  logic [NUM_CH*OUT_W-1:0]   r_stage, r_wave, w_stage_new;
  logic                      r_valid, r_overrun;

  logic [LUT_AW-1:0]         w_addr;
  logic [OUT_W:0]            w_q;
  logic [OUT_W-1:0]          w_f, w_sample, w_scaled;
  logic [SCALE_W:0]          w_m;
  logic [OUT_W+SCALE_W+1:0]  w_prod;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_latch = 1'b0;
    w_write = 1'b0;
    w_last  = 1'b0;
    w_drop  = i_sampleTick && (r_state != IDLE);
    case (r_state)
      IDLE: if (i_sampleTick) begin
        w_next  = ADDR;
        w_latch = 1'b1;
      end
`ifdef LFO_INTERP_EN
      ADDR:   w_next = INTERP;
      INTERP: w_next = CALC;
`else
      ADDR:   w_next = CALC;
`endif
      CALC: begin
        w_write = 1'b1;
        if (r_ch == c_LAST) begin
          w_last = 1'b1;
          w_next = HOLD;
        end else begin
          w_next = ADDR;
        end
      end
      HOLD:    if (bus.outReady) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  assign w_addr = r_p[ACC_W-1 -: LUT_AW];

  // Triangle folds the top OUT_W+1 phase bits, then recentres around zero.
  always_comb begin
    w_q = r_p[ACC_W-1 -: OUT_W+1];
    w_f = w_q[OUT_W] ? ~w_q[OUT_W-1:0] : w_q[OUT_W-1:0];
    case (r_sel)
      2'b00:   w_sample = r_lut;
      2'b01:   w_sample = {~w_f[OUT_W-1], w_f[OUT_W-2:0]};
      2'b10:   w_sample = r_p[ACC_W-1] ? c_NEG : c_POS;
      default: w_sample = {~r_p[ACC_W-1], r_p[ACC_W-2 -: OUT_W-1]};
    endcase
  end

  assign w_m      = (&r_scale) ? {1'b1, {SCALE_W{1'b0}}} : {1'b0, r_scale};
  assign w_prod   = {{(SCALE_W+2){w_sample[OUT_W-1]}}, w_sample}
                  * {{(OUT_W+1){1'b0}}, w_m};
  assign w_scaled = w_prod[SCALE_W +: OUT_W];

  always_comb begin
    w_stage_new = r_stage;
    w_stage_new[int'(r_ch)*OUT_W +: OUT_W] = w_scaled;
  end

`ifdef LFO_INTERP_EN
  logic [OUT_W-1:0]  r_l1;
  logic [7:0]        r_frac;
  logic [OUT_W:0]    w_diff;
  logic [OUT_W+9:0]  w_dprod;
  assign w_diff  = {r_l1[OUT_W-1], r_l1} - {r_lut[OUT_W-1], r_lut};
  assign w_dprod = {{9{w_diff[OUT_W]}}, w_diff} * {{(OUT_W+2){1'b0}}, r_frac};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_l1   <= '0;
      r_frac <= '0;
    end else if (r_state == ADDR) begin
      r_l1   <= w_lut[w_addr + LUT_AW'(1)];
      r_frac <= r_p[ACC_W-1-LUT_AW -: 8];
    end
  end

  logic w_unused_interp;
  assign w_unused_interp = ^{w_dprod[7:0], w_dprod[OUT_W+9:OUT_W+8]};
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_acc     <= '0;
      r_p       <= '0;
      r_tw      <= '0;
      r_off     <= '0;
      r_sel     <= '0;
      r_scale   <= '0;
      r_ch      <= '0;
      r_lut     <= '0;
      r_stage   <= '0;
      r_wave    <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= w_drop;
      if (w_latch) begin
        r_tw    <= i_tuningWord;
        r_off   <= i_phaseOffset;
        r_sel   <= i_waveSel;
        r_scale <= i_scaleFactor;
        r_ch    <= '0;
        r_p     <= r_acc;
      end
      if (r_state == ADDR) r_lut <= w_lut[w_addr];
`ifdef LFO_INTERP_EN
      if (r_state == INTERP) r_lut <= r_lut + w_dprod[8 +: OUT_W];
`endif
      if (w_write) begin
        r_stage <= w_stage_new;
        if (w_last) begin
          r_wave  <= w_stage_new;
          r_acc   <= r_acc + r_tw;
          r_valid <= 1'b1;
        end else begin
          r_ch <= r_ch + c_CH_W'(1);
          r_p  <= r_p + r_off;
        end
      end
      if (r_state == HOLD && bus.outReady) r_valid <= 1'b0;
    end
  end

  logic w_unused;
  assign w_unused = ^{w_prod[SCALE_W-1:0], w_prod[OUT_W+SCALE_W+1 -: 2], r_p};

  assign bus.waveOut  = r_wave;
  assign bus.outValid = r_valid;
  assign o_busy       = (r_state != IDLE);
  assign o_overrun    = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_lfo_gen_multi.sv
// ============================================================================
// Module : tb_lfo_gen_multi
// Brief  : Directed self-checking bench for lfo_gen_multi (NUM_CH=2, OUT_W=16)
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_lfo_gen_multi;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        tick = 1'b0;
  logic [31:0] tw = '0;
  logic [31:0] off = '0;
  logic [1:0]  sel = '0;
  logic [3:0]  sf = '0;
  logic        busy, overrun;
  int          errors = 0;
  int          checks = 0;
  int          lat;

  lfo_gen_multi_if #(.NUM_CH(2), .OUT_W(16)) bus ();

  lfo_gen_multi #(
    .NUM_CH(2), .OUT_W(16), .ACC_W(32), .LUT_AW(8), .SCALE_W(4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .i_sampleTick (tick),
    .i_tuningWord (tw),
    .i_phaseOffset(off),
    .i_waveSel    (sel),
    .i_scaleFactor(sf),
    .bus          (bus),
    .o_busy       (busy),
    .o_overrun    (overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int chan(input int c);
    logic [15:0] v;
    v = bus.waveOut[c*16 +: 16];
    return int'($signed(v));
  endfunction

  task automatic do_reset();
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  // Pulse a tick and wait (bounded) for outValid; latency is checked each time.
  task automatic run_tick();
    tick = 1'b1;
    @(posedge clk); #1;
    tick = 1'b0;
    lat = 1;
    while (bus.outValid !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", lat, 5);
  endtask

  task automatic finish_hs();
    @(posedge clk); #1;
    chk("valid_drop", int'(bus.outValid), 0);
  endtask

  int exp3 [5] = '{-32768, -16384, 0, 16384, -32768};
  int exp4 [3] = '{-32768, 32767, -32768};
  int exp6 [3] = '{0, 804, 1608};

  initial begin
    bus.outReady = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", int'(bus.outValid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_overrun", int'(overrun), 0);
    chk("rst_wave", int'(bus.waveOut), 0);
    reset = 1'b1;
    @(posedge clk); #1;

    // Reset mid-CALC clears output immediately; accumulator restarts at 0
    sel = 2'b11; tw = 32'h4000_0000; off = '0; sf = 4'hF;
    run_tick();
    chk("t1_first", chan(0), -32768);
    finish_hs();
    tick = 1'b1;
    @(posedge clk); #1;
    tick = 1'b0;
    @(posedge clk); #1;
    chk("t1_busy_calc", int'(busy), 1);
    reset = 1'b0;
    #1;
    chk("t1_abort_wave", int'(bus.waveOut), 0);
    chk("t1_abort_valid", int'(bus.outValid), 0);
    chk("t1_abort_busy", int'(busy), 0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    run_tick();
    chk("t1_restart", chan(0), -32768);
    finish_hs();

    // Square with 180 degree spread, unity and half scale
    do_reset();
    sel = 2'b10; tw = '0; off = 32'h8000_0000; sf = 4'hF;
    run_tick();
    chk("t2_ch0", chan(0), 32767);
    chk("t2_ch1", chan(1), -32767);
    finish_hs();
    chk("t2_idle", int'(busy), 0);
    sf = 4'd8;
    run_tick();
    chk("t2_half_ch0", chan(0), 16383);
    chk("t2_half_ch1", chan(1), -16384);
    finish_hs();

    // Saw stepping a quarter cycle per tick, wrapping on the fifth
    do_reset();
    sel = 2'b11; tw = 32'h4000_0000; off = '0; sf = 4'hF;
    for (int i = 0; i < 5; i++) begin
      run_tick();
      chk($sformatf("t3_saw%0d", i), chan(0), exp3[i]);
      finish_hs();
    end

    // Triangle at half-cycle steps alternates extremes
    do_reset();
    sel = 2'b01; tw = 32'h8000_0000;
    for (int i = 0; i < 3; i++) begin
      run_tick();
      chk($sformatf("t4_tri%0d", i), chan(0), exp4[i]);
      finish_hs();
    end

    // Dropped ticks: in HOLD, and in the handshake cycle itself
    do_reset();
    sel = 2'b11; tw = 32'h4000_0000; off = '0; sf = 4'hF;
    bus.outReady = 1'b0;
    run_tick();
    chk("t5_first", chan(0), -32768);
    @(posedge clk); #1;
    tick = 1'b1;
    @(posedge clk); #1;
    tick = 1'b0;
    chk("t5_ovr_pulse", int'(overrun), 1);
    chk("t5_hold_wave", chan(0), -32768);
    chk("t5_hold_valid", int'(bus.outValid), 1);
    @(posedge clk); #1;
    chk("t5_ovr_end", int'(overrun), 0);
    bus.outReady = 1'b1;
    finish_hs();
    run_tick();
    chk("t5_one_step", chan(0), -16384);
    tick = 1'b1;
    @(posedge clk); #1;
    tick = 1'b0;
    chk("t5_hs_ovr", int'(overrun), 1);
    chk("t5_hs_valid", int'(bus.outValid), 0);
    run_tick();
    chk("t5_hs_step", chan(0), 0);
    finish_hs();

    // Sine: zero scale silences, unity scale reproduces table entries
    do_reset();
    sel = 2'b00; tw = 32'h0100_0000; off = 32'h4000_0000; sf = 4'h0;
    run_tick();
    chk("t6_zero_ch0", chan(0), 0);
    chk("t6_zero_ch1", chan(1), 0);
    finish_hs();
    do_reset();
    sf = 4'hF;
    for (int i = 0; i < 3; i++) begin
      run_tick();
      chk($sformatf("t6_sin%0d", i), chan(0), exp6[i]);
      if (i == 0) chk("t6_sin_ch1", chan(1), 32767);
      finish_hs();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
